pipeline_skid_register: RTL and testbench

PIPELINE_SKID_REGISTER -- requirements
Module: pipeline_skid_register

---
 rtl/pipeline_skid_register_pkg.sv | 19 +
 rtl/pipeline_skid_register_entry.sv | 54 +++++
 rtl/pipeline_skid_register.sv | 94 +++++++++
 tb/tb_pipeline_skid_register.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_skid_register_pkg.sv
// Shared defaults and control-field encodings for the writeback skid register.
package pipeline_skid_register_pkg;

    localparam int unsigned XLEN_DEFAULT       = 32;
    localparam int unsigned DATA_WORDS_DEFAULT = 5;
    localparam int unsigned CTRL_W_DEFAULT     = 10;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_LOAD = 2'd1,
        WB_SEL_PC4  = 2'd2,
        WB_SEL_CSR  = 2'd3
    } wb_sel_e;

    // Bit 0: register-file write enable, bit 1: CSR write enable.
    localparam logic [1:0] KILL_MASK_STD = 2'b11;
    localparam logic [CTRL_W_DEFAULT-1:0] KILL_MASK_DEFAULT = CTRL_W_DEFAULT'(KILL_MASK_STD);

endpackage

// File: rtl/pipeline_skid_register_entry.sv
// One valid/data/ctrl storage slot; load wins over kill, kill drops valid and write enables.
module skid_entry
    import pipeline_skid_register_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN_DEFAULT * DATA_WORDS_DEFAULT,
    parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
    parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(KILL_MASK_STD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              kill,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
        end else if (kill) begin
            valid_d = 1'b0;
            ctrl_d  = ctrl_q & ~KILL_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipeline_skid_register.sv
// Two-entry skid register: main drives the outputs, skid absorbs one word while main is stalled.
module pipeline_skid_register
    import pipeline_skid_register_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEFAULT,
    parameter int unsigned DATA_WORDS = DATA_WORDS_DEFAULT,
    parameter int unsigned CTRL_W     = CTRL_W_DEFAULT,
    parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(KILL_MASK_STD)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WORDS*XLEN-1:0] in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WORDS*XLEN-1:0] out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [1:0]                 occupancy
);

    localparam int unsigned DATA_W = DATA_WORDS * XLEN;

    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data,  skid_data;
    logic [CTRL_W-1:0] main_ctrl,  skid_ctrl;

    logic              drain, accept;
    logic              main_load, main_kill, skid_load, skid_kill;
    logic [DATA_W-1:0] main_src_data;
    logic [CTRL_W-1:0] main_src_ctrl;

    always_comb begin
        drain     = main_valid & out_ready;
        accept    = in_valid & ~skid_valid;
        main_load = 1'b0;
        skid_load = 1'b0;
        if (!flush) begin
            // skid is only ever valid behind a valid main, so it refills main first
            if (skid_valid && drain) begin
                main_load = 1'b1;
            end else if (accept && (!main_valid || drain)) begin
                main_load = 1'b1;
            end
            skid_load = accept & main_valid & ~drain;
        end
        main_kill     = flush | (drain & ~main_load);
        skid_kill     = flush | (skid_valid & drain);
        main_src_data = skid_valid ? skid_data : in_data;
        main_src_ctrl = skid_valid ? skid_ctrl : in_ctrl;
    end

    skid_entry #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .KILL_MASK (KILL_MASK)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load),
        .kill    (main_kill),
        .in_data (main_src_data),
        .in_ctrl (main_src_ctrl),
        .valid   (main_valid),
        .data    (main_data),
        .ctrl    (main_ctrl)
    );

    skid_entry #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .KILL_MASK (KILL_MASK)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .kill    (skid_kill),
        .in_data (in_data),
        .in_ctrl (in_ctrl),
        .valid   (skid_valid),
        .data    (skid_data),
        .ctrl    (skid_ctrl)
    );

    // Killing an entry already zeroes its write enables, so out_ctrl needs no output mask.
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Bench for pipeline_skid_register: directed vector table plus random traffic against a queue model,
// driving a default instance and a DATA_WORDS=1/XLEN=64 instance with the same handshakes.
module tb_pipeline_skid_register;

    localparam logic [9:0] KM    = 10'b00_0000_0011;
    localparam logic [9:0] CTRLV = 10'h2A7;

    typedef struct packed {
        logic [159:0] d;
        logic [9:0]   c;
    } ent_t;

    typedef struct {
        bit          iv;
        bit          ordy;
        bit          fl;
        logic [31:0] word;
        bit          ov;
        logic [31:0] oword;
        logic [1:0]  occ;
        bit          ird;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush, in_valid, out_ready;
    logic [159:0] in_data;
    logic [63:0]  in_data_b;
    logic [9:0]   in_ctrl;

    logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [159:0] out_data_a;
    logic [63:0]  out_data_b;
    logic [9:0]   out_ctrl_a, out_ctrl_b;
    logic [1:0]   occ_a, occ_b;

    int   tests = 0;
    int   fails = 0;
    ent_t mq[$];
    ent_t last;
    vec_t tbl[21];

    assign in_data_b = in_data[63:0];

    always #5 clk = ~clk;

    pipeline_skid_register dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_data  (out_data_a),
        .out_ctrl  (out_ctrl_a),
        .occupancy (occ_a)
    );

    pipeline_skid_register #(
        .XLEN       (64),
        .DATA_WORDS (1)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_data   (in_data_b),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_data  (out_data_b),
        .out_ctrl  (out_ctrl_b),
        .occupancy (occ_b)
    );

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int          n;
        logic [9:0]  ec;
        n  = mq.size();
        ec = (n > 0) ? last.c : (last.c & ~KM);
        chk("a_out_valid", out_valid_a, n > 0);
        chk("a_in_ready",  in_ready_a,  n < 2);
        chk("a_occupancy", occ_a,       n[1:0]);
        chk("a_out_ctrl",  out_ctrl_a,  ec);
        chk("a_out_data",  out_data_a,  last.d);
        chk("b_out_valid", out_valid_b, n > 0);
        chk("b_in_ready",  in_ready_b,  n < 2);
        chk("b_occupancy", occ_b,       n[1:0]);
        chk("b_out_ctrl",  out_ctrl_b,  ec);
        chk("b_out_data",  out_data_b,  last.d[63:0]);
    endtask

    // Advance one edge: update the queue model from the current inputs, then check after the edge.
    task automatic tick();
        bit   acc, drn;
        ent_t e;
        acc = in_valid && (mq.size() < 2);
        drn = out_ready && (mq.size() > 0);
        if (flush) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) begin
                e.d = in_data;
                e.c = in_ctrl;
                mq.push_back(e);
            end
        end
        if (mq.size() > 0) last = mq[0];
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic reset_expect();
        chk("rst_a_out_valid", out_valid_a, 1'b0);
        chk("rst_a_in_ready",  in_ready_a,  1'b1);
        chk("rst_a_occupancy", occ_a,       2'd0);
        chk("rst_a_out_ctrl",  out_ctrl_a,  10'd0);
        chk("rst_a_out_data",  out_data_a,  160'd0);
        chk("rst_b_out_valid", out_valid_b, 1'b0);
        chk("rst_b_in_ready",  in_ready_b,  1'b1);
        chk("rst_b_occupancy", occ_b,       2'd0);
        chk("rst_b_out_ctrl",  out_ctrl_b,  10'd0);
        chk("rst_b_out_data",  out_data_b,  64'd0);
        mq.delete();
        last = '0;
    endtask

    function automatic logic [159:0] pack_word(input logic [31:0] w);
        return {w ^ 32'h1111_1111, w, w ^ 32'h2222_2222, ~w, w ^ 32'h3333_3333};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // iv ordy fl word         ov oword        occ ird
        tbl[0]  = '{1, 1, 0, 32'h0000000B, 1, 32'h0000000B, 2'd1, 1};
        tbl[1]  = '{1, 1, 0, 32'h10000020, 1, 32'h10000020, 2'd1, 1};
        tbl[2]  = '{1, 1, 0, 32'hCAFEBABE, 1, 32'hCAFEBABE, 2'd1, 1};
        tbl[3]  = '{0, 1, 0, 32'h0,        0, 32'hCAFEBABE, 2'd0, 1};
        tbl[4]  = '{1, 0, 0, 32'h0000000A, 1, 32'h0000000A, 2'd1, 1};
        tbl[5]  = '{1, 0, 0, 32'hDEADBEEF, 1, 32'h0000000A, 2'd2, 0};
        tbl[6]  = '{1, 0, 0, 32'h33333333, 1, 32'h0000000A, 2'd2, 0};
        tbl[7]  = '{1, 1, 0, 32'h33333333, 1, 32'hDEADBEEF, 2'd1, 1};
        tbl[8]  = '{1, 1, 0, 32'h33333333, 1, 32'h33333333, 2'd1, 1};
        tbl[9]  = '{0, 1, 0, 32'h0,        0, 32'h33333333, 2'd0, 1};
        tbl[10] = '{1, 0, 0, 32'h00000011, 1, 32'h00000011, 2'd1, 1};
        tbl[11] = '{1, 0, 0, 32'h00000022, 1, 32'h00000011, 2'd2, 0};
        tbl[12] = '{1, 1, 0, 32'h00000044, 1, 32'h00000022, 2'd1, 1};
        tbl[13] = '{1, 1, 0, 32'h00000044, 1, 32'h00000044, 2'd1, 1};
        tbl[14] = '{0, 1, 0, 32'h0,        0, 32'h00000044, 2'd0, 1};
        tbl[15] = '{1, 0, 0, 32'h00000055, 1, 32'h00000055, 2'd1, 1};
        tbl[16] = '{1, 0, 0, 32'h00000066, 1, 32'h00000055, 2'd2, 0};
        tbl[17] = '{1, 0, 1, 32'h00000077, 0, 32'h00000055, 2'd0, 1};
        tbl[18] = '{1, 1, 0, 32'h00000088, 1, 32'h00000088, 2'd1, 1};
        tbl[19] = '{0, 1, 0, 32'h0,        0, 32'h00000088, 2'd0, 1};
        tbl[20] = '{1, 1, 1, 32'h00000099, 0, 32'h00000088, 2'd0, 1};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        #3;
        reset_expect();
        #17;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            in_data   = pack_word(tbl[i].word);
            in_ctrl   = CTRLV;
            tick();
            chk("tbl_out_valid", out_valid_a,         tbl[i].ov);
            chk("tbl_alu_word",  out_data_a[127:96],  tbl[i].oword);
            chk("tbl_occupancy", occ_a,               tbl[i].occ);
            chk("tbl_in_ready",  in_ready_a,          tbl[i].ird);
            chk("tbl_out_ctrl",  out_ctrl_a,          tbl[i].ov ? CTRLV : (CTRLV & ~KM));
        end
        flush = 1'b0;

        // Reset pulse while two entries are held: both must vanish without being emitted.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = pack_word(32'hAAAA0001);
        tick();
        in_data   = pack_word(32'hAAAA0002);
        tick();
        chk("pre_rst_occupancy", occ_a, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        reset_expect();
        #29;
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = pack_word(32'hBBBB0003);
        in_ctrl   = CTRLV;
        tick();
        chk("post_rst_first_word", out_data_a[127:96], 32'hBBBB0003);
        in_valid = 1'b0;
        tick();

        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            in_ctrl   = 10'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
